i2s_4bit_stream_rx: RTL and testbench
=====================================

// Module: i2s_4bit_stream_rx
// PURPOSE
//  Receive side of the 4-bit framed stream link (qclk/frame/qdata[3:0]).
//  Samples the incoming lines, rebuilds 32-bit words (8 nibbles, MSB first) and queues them in a FIFO.
//  The FIFO is drained over a valid/ready handshake.
//  Sits between the ESP32-facing pins and the core logic; it is the counterpart of the 4-bit stream transmitter.
// PARAMETERS
//  FIFO_DEPTH       32                   words of buffering; power of two, >=4
//  FIFO_ADDR_WIDTH  $clog2(FIFO_DEPTH)   pointer width (derived)
//  SYNC_STAGES      2                    synchroniser flops on qclk/frame/qdata, >=2
// PORTS
//  clk             in   1     system clock; must be >=4x qclk frequency
//  rst_n           in   1     asynchronous, active-low reset
//  qclk            in   1     link clock, asynchronous to clk
//  frame           in   1     high during first nibble of a word
//  qdata           in   4     link data; changes on qclk falling edge
//  m_data          out  32    head-of-FIFO word (show-ahead)
//  m_valid         out  1     FIFO not empty
//  m_ready         in   1     consumer accepts m_data when m_valid&m_ready
//  fifo_count      out  FIFO_ADDR_WIDTH+1  words held
//  fifo_full       out  1     fifo_count==FIFO_DEPTH
//  overflow        out  1     sticky: completed word dropped because FIFO full
//  frame_err       out  1     sticky: frame seen before 8 nibbles completed
//  clear_err       in   1     synchronous clear of overflow/frame_err (1 cycle)
//  word_cnt        out  16    completed words received (written or dropped), wraps
// BEHAVIOUR
//  Reset: all outputs 0, m_data=0, state IDLE, pointers/counters 0; FIFO contents undefined.
//  Sync: qclk, frame, qdata each pass SYNC_STAGES flops (same depth, aligned).
//   qclk_rise = sync qclk 0->1 between last two stages, one clk pulse.
//   All sampling uses synced frame/qdata on qclk_rise only.
//  FSM (advances only on qclk_rise):
//   IDLE: frame=1 -> shift={28'h0,qdata}, nib_cnt=1, go RECV; frame=0 -> ignore (gap nibbles).
//   RECV, frame=0: shift={shift[27:0],qdata}, nib_cnt++.
//   RECV, nib_cnt reaches 8: word complete -> push, word_cnt++, go IDLE.
//   RECV, frame=1 with nib_cnt<8: discard partial, set frame_err, restart word with this nibble (nib_cnt=1, stay RECV).
//  Push occurs on the clk edge of the 8th qclk_rise.
//   Word visible on m_data with m_valid=1 the next cycle if FIFO was empty.
//   Pin-to-valid latency: SYNC_STAGES+2 clk from the 8th qclk rising edge.
//  FIFO: show-ahead; pop when m_valid&m_ready.
//   Push with fifo_full at start of cycle -> word dropped and overflow=1, even if a pop occurs that cycle.
//   Push and pop in the same cycle with count in 1..DEPTH-1 -> count unchanged.
//   Pop on empty is ignored.
//   m_data must stay stable while m_valid&!m_ready.
//   Pointers are FIFO_ADDR_WIDTH+1 bits and wrap naturally.
//  clear_err has priority below a same-cycle set (set wins).
//  word_cnt wraps 16'hFFFF->0.
//  Reset mid-word: partial word lost, FIFO emptied.
// STRUCTURE
//  Package a2_stream_pkg: NIBBLES_PER_WORD=8, STREAM_WORD_W=32, nibble/word typedefs, rx state enum {IDLE,RECV}.
//   Shared with the transmitter.
//  Sub-module stream_rx_fifo: show-ahead sync FIFO with count/full/overflow-drop.
//  Top holds the synchroniser, edge detect, FSM/shift register and flags.
// TESTING
//  1. Single word 0xDEADBEEF, qclk=clk/4, 2-cycle gap -> m_valid after SYNC_STAGES+2 clk; m_data=DEADBEEF; word_cnt=1.
//  2. 40 back-to-back words, m_ready=0, DEPTH=32 -> fifo_full, count=32, overflow=1, word_cnt=40.
//     Then drain: words 0..31 in order; words 32..39 absent.
//  3. Frame reasserted after 5 nibbles, then full word 0x12345678 -> frame_err=1; only 12345678 queued.
//  4. Sustained stream with m_ready=1 and m_ready toggling 50% -> no loss, order kept, m_data stable while stalled.
//  5. Push and pop in same cycle at count=1 and at count=DEPTH -> count 1 stays 1.
//     At full: pop happens, push dropped, overflow=1.
//  6. rst_n low mid-word and with FIFO half full -> outputs 0 immediately.
//     After release, next word 0xA5A5A5A5 is received correctly.
//  7. clear_err pulse -> overflow/frame_err return to 0.

Source files
------------

// File: rtl/a2_stream_pkg.sv
// Shared definitions for the 4-bit framed stream link (qclk/frame/qdata[3:0]).
// Used by both the receiver and the transmitter so that word size, nibble
// count and the receiver state encoding stay in one place.
package a2_stream_pkg;

    localparam int NIBBLES_PER_WORD = 8;
    localparam int STREAM_WORD_W    = 32;

    typedef logic [3:0]               nibble_t;
    typedef logic [STREAM_WORD_W-1:0] word_t;

    // Receiver word-assembly state
    typedef enum logic {
        IDLE = 1'b0,   // waiting for a frame-marked nibble
        RECV = 1'b1    // collecting nibbles 2..8 of a word
    } rx_state_e;

endpackage

// File: rtl/stream_rx_fifo.sv
// Show-ahead synchronous word FIFO for the stream receiver.
//  clk, rst_n     : clock, asynchronous active-low reset
//  push_i/data_i  : write request and word (dropped when full at start of cycle)
//  pop_i          : consumer ready; pops when the FIFO is not empty
//  data_o/valid_o : head word (0 when empty) and not-empty flag
//  count_o/full_o : occupancy and full flag
//  drop_o         : one-cycle pulse when a push was refused because full
module stream_rx_fifo
    import a2_stream_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  word_t         data_i,
    input  logic          pop_i,
    output word_t         data_o,
    output logic          valid_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          drop_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // One extra pointer bit distinguishes full from empty; pointers wrap freely.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    word_t       mem [DEPTH];

    logic do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == DEPTH_C);
    assign valid_o = (count_o != '0);

    // Fullness is judged at the start of the cycle, so a same-cycle pop does
    // not make room for the incoming word.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;
    assign drop_o  = push_i & full_o;

    // Contents are undefined after reset; zero the output while empty so the
    // head word reads 0 out of reset and never shows stale data.
    assign data_o = valid_o ? mem[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/i2s_4bit_stream_rx.sv
// Receive side of the 4-bit framed stream link.
// Synchronises qclk/frame/qdata into clk, rebuilds 32-bit words from eight
// MSB-first nibbles (frame marks the first nibble) and queues them.
//  clk, rst_n        : system clock (>=4x qclk), asynchronous active-low reset
//  qclk, frame, qdata: link pins, asynchronous to clk
//  m_data/m_valid/m_ready : show-ahead FIFO drain handshake
//  fifo_count/fifo_full   : occupancy
//  overflow, frame_err    : sticky error flags, cleared by clear_err
//  word_cnt               : completed words (written or dropped), wraps
module i2s_4bit_stream_rx
    import a2_stream_pkg::*;
#(
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       qclk,
    input  logic                       frame,
    input  logic [3:0]                 qdata,
    output logic [31:0]                m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       fifo_full,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clear_err,
    output logic [15:0]                word_cnt
);

    // ---------------- synchronisers ----------------
    // All three inputs use the same depth so frame/qdata stay aligned with
    // the qclk edge they were launched against.
    logic [SYNC_STAGES-1:0]      qclk_sync_q;
    logic [SYNC_STAGES-1:0]      frame_sync_q;
    logic [SYNC_STAGES-1:0][3:0] qdata_sync_q;
    logic                        qclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qclk_sync_q  <= '0;
            frame_sync_q <= '0;
            qdata_sync_q <= '0;
            qclk_prev_q  <= 1'b0;
        end else begin
            qclk_sync_q  <= {qclk_sync_q[SYNC_STAGES-2:0], qclk};
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], frame};
            qdata_sync_q <= {qdata_sync_q[SYNC_STAGES-2:0], qdata};
            qclk_prev_q  <= qclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic    qclk_rise;
    logic    frame_s;
    nibble_t qdata_s;

    // Single clk pulse per link clock rising edge.
    assign qclk_rise = qclk_sync_q[SYNC_STAGES-1] & ~qclk_prev_q;
    assign frame_s   = frame_sync_q[SYNC_STAGES-1];
    assign qdata_s   = qdata_sync_q[SYNC_STAGES-1];

    // ---------------- word assembly ----------------
    rx_state_e   state_q, state_d;
    logic [3:0]  nib_cnt_q, nib_cnt_d;
    word_t       shift_q, shift_d;
    logic        push_q, push_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        ferr_set;

    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        word_cnt_d = word_cnt_q;
        ferr_set   = 1'b0;
        if (qclk_rise) begin
            case (state_q)
                IDLE: begin
                    // Nibbles without frame between words are gap filler.
                    if (frame_s) begin
                        shift_d   = {{(STREAM_WORD_W-4){1'b0}}, qdata_s};
                        nib_cnt_d = 4'd1;
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    if (frame_s) begin
                        // Early frame: drop the partial word, start over here.
                        ferr_set  = 1'b1;
                        shift_d   = {{(STREAM_WORD_W-4){1'b0}}, qdata_s};
                        nib_cnt_d = 4'd1;
                    end else begin
                        shift_d   = {shift_q[STREAM_WORD_W-5:0], qdata_s};
                        nib_cnt_d = nib_cnt_q + 4'd1;
                        if (nib_cnt_q == 4'(NIBBLES_PER_WORD - 1)) begin
                            push_d     = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                            nib_cnt_d  = 4'd0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nib_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // ---------------- FIFO ----------------
    // shift_q holds the finished word for several clk cycles (next qclk rise
    // is >=4 clk away), so it feeds the FIFO directly alongside push_q.
    logic fifo_drop;

    stream_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (m_ready),
        .data_o  (m_data),
        .valid_o (m_valid),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    // ---------------- sticky flags ----------------
    // A set in the same cycle as clear_err wins.
    logic overflow_q, overflow_d;
    logic frame_err_q, frame_err_d;

    always_comb begin
        overflow_d  = fifo_drop ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
        frame_err_d = ferr_set  ? 1'b1 : (clear_err ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_i2s_4bit_stream_rx.sv
// Directed bench for i2s_4bit_stream_rx. Link pins are driven on the clk
// falling edge with qclk = clk/4 (2 low, 2 high); outputs are sampled on the
// falling edge as well.
module tb_i2s_4bit_stream_rx;

    localparam int DEPTH = 32;
    localparam int SS    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qclk, frame, m_ready, clear_err;
    logic [3:0]  qdata;
    logic [31:0] m_data;
    logic        m_valid, fifo_full, overflow, frame_err;
    logic [5:0]  fifo_count;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    // consumer-side state for the streaming test
    int          idx, cyc;
    logic        stalled, r;
    logic [31:0] held;

    i2s_4bit_stream_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .qclk       (qclk),
        .frame      (frame),
        .qdata      (qdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clear_err  (clear_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_nib(input logic f, input logic [3:0] n);
        @(negedge clk); qclk = 1'b0; frame = f; qdata = n;
        @(negedge clk);
        @(negedge clk); qclk = 1'b1;
        @(negedge clk);
    endtask

    // Returns one clk after the 8th qclk rising edge.
    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 8; k++) send_nib(k == 0, w[31-4*k -: 4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; qclk = 1'b0; frame = 1'b0; qdata = 4'h0;
        m_ready = 1'b0; clear_err = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(2);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
        return base + 32'(i) * 32'h0101_0101;
    endfunction

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_m_valid",   32'(m_valid),    32'd0);
        chk("rst_m_data",    m_data,          32'd0);
        chk("rst_count",     32'(fifo_count), 32'd0);
        chk("rst_full",      32'(fifo_full),  32'd0);
        chk("rst_overflow",  32'(overflow),   32'd0);
        chk("rst_frame_err", 32'(frame_err),  32'd0);
        chk("rst_word_cnt",  32'(word_cnt),   32'd0);

        // ---- 1: single word, gap filler, latency ----
        wait_n(2);
        send_nib(1'b0, 4'h7);          // gap nibble, ignored in IDLE
        send_word(32'hDEAD_BEEF);
        wait_n(SS);                    // SS+1 clk after the 8th rise
        chk("t1_valid_early", 32'(m_valid), 32'd0);
        wait_n(1);                     // SS+2 clk
        chk("t1_valid",     32'(m_valid),    32'd1);
        chk("t1_data",      m_data,          32'hDEAD_BEEF);
        chk("t1_word_cnt",  32'(word_cnt),   32'd1);
        chk("t1_count",     32'(fifo_count), 32'd1);
        chk("t1_frame_err", 32'(frame_err),  32'd0);

        // ---- 2: 40 words into a 32-deep FIFO ----
        do_reset();
        for (int i = 0; i < 40; i++) send_word(word_of(32'hC000_0000, i));
        wait_n(4);
        chk("t2_full",     32'(fifo_full),  32'd1);
        chk("t2_count",    32'(fifo_count), 32'd32);
        chk("t2_overflow", 32'(overflow),   32'd1);
        chk("t2_word_cnt", 32'(word_cnt),   32'd40);
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("t2_drain", m_data, word_of(32'hC000_0000, i));
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("t2_empty", 32'(m_valid),    32'd0);
        chk("t2_count0", 32'(fifo_count), 32'd0);

        // ---- 3: early frame after 5 nibbles, then a full word ----
        send_nib(1'b1, 4'h1);
        send_nib(1'b0, 4'h2);
        send_nib(1'b0, 4'h3);
        send_nib(1'b0, 4'h4);
        send_nib(1'b0, 4'h5);
        send_word(32'h1234_5678);
        wait_n(4);
        chk("t3_frame_err", 32'(frame_err),  32'd1);
        chk("t3_count",     32'(fifo_count), 32'd1);
        chk("t3_data",      m_data,          32'h1234_5678);
        chk("t3_word_cnt",  32'(word_cnt),   32'd41);
        chk("t3_overflow",  32'(overflow),   32'd1);

        // ---- 7: clear_err ----
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        chk("t7_overflow",  32'(overflow),   32'd0);
        chk("t7_frame_err", 32'(frame_err),  32'd0);
        chk("t7_count",     32'(fifo_count), 32'd1);
        m_ready = 1'b1;
        wait_n(1);
        m_ready = 1'b0;
        chk("t7_drained", 32'(m_valid), 32'd0);

        // ---- 4: sustained stream, ready held then toggling ----
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            fork
                begin
                    for (int i = 0; i < 12; i++) send_word(word_of(32'h4000_0000 + 32'(ph << 24), i));
                end
                begin
                    idx = 0; cyc = 0; stalled = 1'b0; held = '0;
                    while (idx < 12 && cyc < 3000) begin
                        @(negedge clk);
                        cyc++;
                        if (stalled) chk("t4_stall_stable", m_data, held);
                        r = (ph == 0) ? 1'b1 : cyc[0];
                        m_ready = r;
                        if (m_valid && r) begin
                            chk("t4_stream", m_data, word_of(32'h4000_0000 + 32'(ph << 24), idx));
                            idx++;
                        end
                        stalled = m_valid && !r;
                        held    = m_data;
                    end
                    chk("t4_received", 32'(idx), 32'd12);
                end
            join
            @(negedge clk); m_ready = 1'b0;
        end
        chk("t4_overflow", 32'(overflow),  32'd0);
        chk("t4_word_cnt", 32'(word_cnt),  32'd24);

        // ---- 5a: push and pop together at count=1 ----
        do_reset();
        send_word(32'h1111_1111);
        wait_n(4);
        chk("t5_count1", 32'(fifo_count), 32'd1);
        send_word(32'h2222_2222);
        wait_n(2);                     // FIFO write lands on the next edge
        m_ready = 1'b1;
        wait_n(1);
        m_ready = 1'b0;
        chk("t5_count_same", 32'(fifo_count), 32'd1);
        chk("t5_data",       m_data,          32'h2222_2222);
        chk("t5_no_ovf",     32'(overflow),   32'd0);

        // ---- 5b: push and pop together at full ----
        do_reset();
        for (int i = 0; i < 32; i++) send_word(word_of(32'h3000_0000, i));
        wait_n(4);
        chk("t5_full", 32'(fifo_full), 32'd1);
        send_word(32'hFEED_FACE);
        wait_n(2);
        m_ready = 1'b1;
        wait_n(1);
        m_ready = 1'b0;
        chk("t5_full_count", 32'(fifo_count), 32'd31);
        chk("t5_full_ovf",   32'(overflow),   32'd1);
        chk("t5_full_flag",  32'(fifo_full),  32'd0);
        chk("t5_full_head",  m_data,          word_of(32'h3000_0000, 1));
        chk("t5_full_wcnt",  32'(word_cnt),   32'd33);

        // ---- 6: reset mid-word with FIFO half full ----
        do_reset();
        for (int i = 0; i < 16; i++) send_word(word_of(32'h6000_0000, i));
        send_nib(1'b1, 4'hA);
        send_nib(1'b0, 4'hB);
        send_nib(1'b0, 4'hC);
        wait_n(4);
        chk("t6_half", 32'(fifo_count), 32'd16);
        @(negedge clk);
        rst_n = 1'b0; qclk = 1'b0; frame = 1'b0;
        #1;
        chk("t6_valid",     32'(m_valid),    32'd0);
        chk("t6_data",      m_data,          32'd0);
        chk("t6_count",     32'(fifo_count), 32'd0);
        chk("t6_word_cnt",  32'(word_cnt),   32'd0);
        chk("t6_frame_err", 32'(frame_err),  32'd0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(2);
        send_word(32'hA5A5_A5A5);
        wait_n(4);
        chk("t6_after_data",  m_data,          32'hA5A5_A5A5);
        chk("t6_after_count", 32'(fifo_count), 32'd1);
        chk("t6_after_ferr",  32'(frame_err),  32'd0);
        chk("t6_after_wcnt",  32'(word_cnt),   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
